seg7_scan_decoder: RTL

//  Monitors a multiplexed 4-digit common-anode 7-segment bus and recovers the displayed hex digits.

---
 rtl/seg7_scan_decoder_if.sv | 10 +
 rtl/seg7_scan_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 4-digit common-anode 7-segment bus (all lines active-low).
// master = segment controller, slave = readback decoder.
interface seg7_scan_decoder_if;
  logic Ca, Cb, Cc, Cd, Ce, Cf, Cg;
  logic DP;
  logic AN0, AN1, AN2, AN3;

  modport master (output Ca, Cb, Cc, Cd, Ce, Cf, Cg, DP, AN0, AN1, AN2, AN3);
  modport slave  (input  Ca, Cb, Cc, Cd, Ce, Cf, Cg, DP, AN0, AN1, AN2, AN3);
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a scanned 7-segment bus with settle filtering and error flags.
// Define SEG_DECODE_STATS_EN to add the frame_count and bad_count statistics outputs.
module seg7_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                System_Clock,
  input  logic                Reset,
  seg7_scan_decoder_if.slave  bus,
  output logic [3:0]          digit0,
  output logic [3:0]          digit1,
  output logic [3:0]          digit2,
  output logic [3:0]          digit3,
  output logic [3:0]          dp_out,
  output logic [3:0]          digit_valid,
  output logic                frame_done,
  output logic                bad_pattern,
  output logic                multi_an_err,
  output logic                stalled
`ifdef SEG_DECODE_STATS_EN
  ,
  output logic [15:0]         frame_count,
  output logic [7:0]          bad_count
`endif
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SettleMax = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TmoMax    = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StCaptured} state_e;

  state_e state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // {AN3..AN0, Ca..Cg, DP}
  logic [11:0] bus_q, bus_prev_q;
  logic [3:0]  an_low;
  logic [6:0]  seg;
  logic        one_an, multi_an, changed, capture;
  logic [1:0]  an_idx;
  logic        glyph_ok;
  logic [3:0]  glyph_val;

  logic [3:0] digit_q [4];
  logic [3:0] digit_d [4];
  logic [3:0] dp_q, dp_d, valid_q, valid_d, seen_q, seen_d;
  logic       bad_q, bad_d, multi_q, multi_d, stalled_q, stalled_d;

  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  assign an_low   = ~bus_q[11:8];
  assign seg      = bus_q[7:1];
  assign one_an   = $onehot(an_low);
  assign multi_an = (an_low != 4'h0) && !one_an;
  assign changed  = (bus_q != bus_prev_q);
  assign {glyph_ok, glyph_val} = decode_glyph(seg);

  always_comb begin
    an_idx = 2'd0;
    unique case (an_low)
      4'b0010: an_idx = 2'd1;
      4'b0100: an_idx = 2'd2;
      4'b1000: an_idx = 2'd3;
      default: an_idx = 2'd0;
    endcase
  end

  // State register; the bus register resets to idle levels (all lines high).
  always_ff @(posedge System_Clock) begin
    if (Reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bus_q      <= '1;
      bus_prev_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_q      <= {bus.AN3, bus.AN2, bus.AN1, bus.AN0,
                     bus.Ca, bus.Cb, bus.Cc, bus.Cd, bus.Ce, bus.Cf, bus.Cg, bus.DP};
      bus_prev_q <= bus_q;
    end
  end

  // Next-state logic; a change always wins over a completing settle count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (one_an) begin
          state_d = StSettle;
          cnt_d   = SW'(1);
        end
      end
      StSettle: begin
        if (changed) begin
          if (one_an) cnt_d = SW'(1);
          else        state_d = StIdle;
        end else if (cnt_q == SettleMax) begin
          state_d = StCaptured;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCaptured: begin
        if (changed) begin
          if (one_an) begin
            state_d = StSettle;
            cnt_d   = SW'(1);
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode of FSM state.
  always_comb begin
    capture    = (state_q == StSettle) && !changed && (cnt_q == SettleMax);
    frame_done = (seen_q == 4'hF);
  end

  // Capture datapath; the seen clear on frame_done precedes a same-cycle capture.
  always_comb begin
    digit_d   = digit_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    bad_d     = bad_q;
    stalled_d = stalled_q;
    multi_d   = multi_q | multi_an;
    seen_d    = frame_done ? 4'h0 : seen_q;
    tmo_d     = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;
    if (capture) begin
      tmo_d     = '0;
      stalled_d = 1'b0;
      if (glyph_ok) begin
        digit_d[an_idx] = glyph_val;
        dp_d[an_idx]    = ~bus_q[0];
        valid_d[an_idx] = 1'b1;
        seen_d[an_idx]  = 1'b1;
      end else begin
        valid_d[an_idx] = 1'b0;
        bad_d           = 1'b1;
      end
    end else if (tmo_d == TmoMax) begin
      stalled_d = 1'b1;
      valid_d   = 4'h0;
    end
  end

  always_ff @(posedge System_Clock) begin
    if (Reset) begin
      digit_q   <= '{default: '0};
      dp_q      <= '0;
      valid_q   <= '0;
      seen_q    <= '0;
      bad_q     <= 1'b0;
      multi_q   <= 1'b0;
      stalled_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      digit_q   <= digit_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      bad_q     <= bad_d;
      multi_q   <= multi_d;
      stalled_q <= stalled_d;
      tmo_q     <= tmo_d;
    end
  end

  assign digit0       = digit_q[0];
  assign digit1       = digit_q[1];
  assign digit2       = digit_q[2];
  assign digit3       = digit_q[3];
  assign dp_out       = dp_q;
  assign digit_valid  = valid_q;
  assign bad_pattern  = bad_q;
  assign multi_an_err = multi_q;
  assign stalled      = stalled_q;

`ifdef SEG_DECODE_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  bad_cnt_q;

  always_ff @(posedge System_Clock) begin
    if (Reset) begin
      frame_cnt_q <= '0;
      bad_cnt_q   <= '0;
    end else begin
      if (frame_done) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (capture && !glyph_ok && (bad_cnt_q != 8'hFF)) bad_cnt_q <= bad_cnt_q + 1'b1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign bad_count   = bad_cnt_q;
`endif

endmodule
